servo_pwm_multi: RTL
====================

# servo_pwm_multi

Multi-channel, double-buffered PWM generator for the remote-servo datapath. It drives CH outputs in lockstep from one shared period counter. Duty and period writes arrive through a valid/ready config port into shadow registers. Shadow values are transferred to the active registers only at a period boundary, so a pulse is never truncated or glitched mid-frame.

## Interface
- CH, 4: number of PWM channels (1..16)
- WIDTH, 20: counter, duty and period width in bits (20 bits covers 20 ms at 50 MHz)
- PERIOD_RST, 999999: active and shadow period after reset
- MIN_PULSE, 50000: lower duty clamp (used only with PWM_CLAMP_EN)
- MAX_PULSE, 100000: upper duty clamp (used only with PWM_CLAMP_EN)
- ADDR_W, $clog2(CH+1): config address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global run enable
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high together with cfg_valid
- cfg_addr  in  ADDR_W  0..CH-1 selects a channel duty register; CH selects the period register; higher addresses are ignored but still accepted
- cfg_data  in  WIDTH  write data
- pwm_out  out  CH  registered PWM outputs; bit i is channel i
- frame_tick  out  1  one-cycle pulse marking the first cycle of each period
- pending  out  1  high while any shadow register holds a value not yet loaded into the active registers

## Operation
- Reset values:
  - counter = 0
  - every duty register (active and shadow) = 0
  - period (active and shadow) = PERIOD_RST
  - pwm_out = 0, frame_tick = 0, pending = 0, cfg_ready = 0
- cfg_ready goes to 1 on the first clock after reset release and stays 1.
- A write takes effect when cfg_valid && cfg_ready on a rising edge. It updates the addressed shadow register and sets pending.
- Counter, when en = 1: counts 0..period_a inclusive, then wraps to 0. Each period is therefore period_a+1 cycles.
- Wrap cycle: the cycle in which counter == period_a and en = 1.
  - On the wrap cycle, every active register loads from its shadow and pending clears.
  - A write accepted in the same wrap cycle bypasses the shadow: its data loads into both shadow and active, and pending ends the cycle at 0.
- en = 0:
  - counter is forced to 0, and pwm_out and frame_tick are forced to 0.
  - Active registers load from shadow every cycle, so pending is 0 one cycle after the last write.
  - Writes are still accepted.
- Output rule, every cycle with en = 1: pwm_out[i] <= (counter < duty_a[i]).
  - duty_a = 0 gives constant low.
  - duty_a > period_a gives constant high.
- Period 0: the counter stays at 0, every cycle is a wrap cycle, and frame_tick is high continuously.
- Comparisons are unsigned WIDTH-bit. No internal arithmetic overflows, because the counter never exceeds period_a.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). Pending writes are discarded.

## Timing
- pwm_out lags the counter value it is computed from by 1 cycle.
- frame_tick is registered and goes high in the cycle after counter == 0 is evaluated, aligned with the first pwm_out sample of the period.
- Write-to-output latency:
  - With en = 1: the write lands in shadow, the next wrap loads it into active, and pwm_out reflects it from the second cycle of the following period onward. Worst case is period_a+2 cycles after acceptance.
  - With en = 0: the active registers hold the new value 1 cycle after acceptance.
- en rising edge: counter is 0 in that cycle, and the first pwm_out and frame_tick appear 1 cycle later.

## Configuration
- PWM_CLAMP_EN, defined: duty writes saturate to [MIN_PULSE, MAX_PULSE] on entry to the shadow register.
  - Reset duty stays 0, which means the output is off until the first write.
  - Period writes are never clamped.
- PWM_CLAMP_EN, undefined: duty writes are stored raw, and the MIN_PULSE/MAX_PULSE parameters are unused.

## Test plan
- Reset, then en = 1, PERIOD_RST = 9, no writes. Required: pwm_out = 0 throughout; frame_tick pulses every 10 cycles; pending = 0.
- period = 9, write duty ch0 = 3 and ch1 = 10 with en = 0, then en = 1. Required: ch0 is high 3 of every 10 cycles; ch1 is constant high; ch2 and ch3 stay low.
- Mid-frame write of ch0 = 7 at counter = 4. Required: the current frame keeps width 3; pending stays high until the wrap; the next frame is width 7.
- Write ch0 = 5 exactly on the wrap cycle. Required: the very next frame is width 5; pending stays 0.
- Write period = 0 with ch0 = 1. Required: after the wrap, ch0 is constant high and frame_tick is constant high. Then assert rst_n low at a random cycle: all outputs go to 0 immediately.
- PWM_CLAMP_EN build with MIN_PULSE = 2 and MAX_PULSE = 6, period = 9. Write ch0 = 0 and ch1 = 9. Required: widths 2 and 6. Rebuild without the macro: widths 0 and 9.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: CH-channel double-buffered PWM sharing one period counter.
// Optional build macro PWM_CLAMP_EN saturates duty writes to [MIN_PULSE, MAX_PULSE].
module servo_pwm_multi #(
    parameter int CH         = 4,
    parameter int WIDTH      = 20,
    parameter int PERIOD_RST = 999999,
    parameter int MIN_PULSE  = 50000,
    parameter int MAX_PULSE  = 100000,
    parameter int ADDR_W     = $clog2(CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    output logic [CH-1:0]     pwm_out,
    output logic              frame_tick,
    output logic              pending
);
    logic [WIDTH-1:0] cnt, period_a, period_s, duty_wd;
    logic [WIDTH-1:0] duty_a [CH];
    logic [WIDTH-1:0] duty_s [CH];
    logic wr, wrap, load, hit_period;

    if (MIN_PULSE > MAX_PULSE) begin : g_bad_clamp
        $error("MIN_PULSE exceeds MAX_PULSE");
    end

`ifdef PWM_CLAMP_EN
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_PULSE);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_PULSE);
    // duty writes saturate before entering the shadow register
    always_comb duty_wd = cfg_data < MIN_W ? MIN_W : (cfg_data > MAX_W ? MAX_W : cfg_data);
`else
    // duty writes are stored raw
    always_comb duty_wd = cfg_data;
`endif

    // accepted write, frame boundary and shadow-to-active transfer strobes
    always_comb begin
        wr         = cfg_valid && cfg_ready;
        wrap       = en && cnt == period_a;
        load       = !en || wrap;
        hit_period = wr && cfg_addr == ADDR_W'(CH);
    end

    // shared period counter, handshake readiness and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cfg_ready <= 1'b0;
            pending   <= 1'b0;
        end else begin
            cnt       <= load ? '0 : cnt + WIDTH'(1);
            cfg_ready <= 1'b1;
            pending   <= load ? 1'b0 : (wr && cfg_addr <= ADDR_W'(CH)) ? 1'b1 : pending;
        end
    end

    // period shadow/active pair; a write on a load cycle bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s <= WIDTH'(PERIOD_RST);
            period_a <= WIDTH'(PERIOD_RST);
        end else begin
            if (hit_period) period_s <= cfg_data;
            if (load) period_a <= hit_period ? cfg_data : period_s;
        end
    end

    // per-channel duty shadow/active pairs with the same bypass rule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                duty_s[i] <= '0;
                duty_a[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr && cfg_addr == ADDR_W'(i)) duty_s[i] <= duty_wd;
                if (load) duty_a[i] <= (wr && cfg_addr == ADDR_W'(i)) ? duty_wd : duty_s[i];
            end
        end
    end

    // registered outputs, forced low while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) pwm_out[i] <= en && (cnt < duty_a[i]);
            frame_tick <= en && cnt == '0;
        end
    end
endmodule
